div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// div_seq: multi-cycle 32-bit divider for the EX stage.
//
// Restoring shift-subtract on a 65-bit partial remainder, one step per cycle,
// 32 steps. Operands are converted to magnitudes at load. The quotient and
// remainder signs are applied when the result is registered in END.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active high
//   signed_div_i  1 = two's-complement divide, 0 = unsigned divide
//   opdata1_i     dividend (sampled only at load)
//   opdata2_i     divisor  (sampled only at load)
//   start_i       divide request, held until the result is consumed
//   annul_i       flush: abort the divide in flight, block a new one
//   result_o      {remainder, quotient}, valid while ready_o = 1
//   ready_o       result valid
//   stallreq_o    pipeline stall request while a divide is pending
//
// Build option:
//   DIV_ZERO_FASTPATH_EN  when defined, a zero divisor skips the iteration
//                         (BYZERO state) and returns an all-zero result.

module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

`ifdef DIV_ZERO_FASTPATH_EN
    typedef enum logic [1:0] {StFree, StOn, StEnd, StByZero} state_e;
`else
    typedef enum logic [1:0] {StFree, StOn, StEnd} state_e;
`endif

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [64:0] pr_q;        // {partial remainder, dividend/quotient bits}
    logic [31:0] divisor_q;
    logic        neg_quot_q;
    logic        neg_rem_q;

    logic        op1_neg, op2_neg;
    logic [31:0] op1_mag, op2_mag;
    logic [33:0] diff;
    logic [64:0] pr_step;
    logic [31:0] quot_fix, rem_fix;
    logic        pending;

    always_comb begin
        op1_neg = signed_div_i & opdata1_i[31];
        op2_neg = signed_div_i & opdata2_i[31];
        op1_mag = op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
        op2_mag = op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;

        // Trial subtraction of the divisor from the left-shifted remainder;
        // diff[33] set means the shifted remainder is below the divisor.
        diff    = {pr_q[64:32], pr_q[31]} - {2'b00, divisor_q};
        pr_step = diff[33] ? {pr_q[63:0], 1'b0}
                           : {diff[32:0], pr_q[30:0], 1'b1};

        quot_fix = neg_quot_q ? (~pr_q[31:0] + 32'd1) : pr_q[31:0];
        rem_fix  = neg_rem_q  ? (~pr_q[63:32] + 32'd1) : pr_q[63:32];

`ifdef DIV_ZERO_FASTPATH_EN
        pending = (state_q == StOn) || (state_q == StByZero);
`else
        pending = (state_q == StOn);
`endif
        stallreq_o = ~rst & (pending | ((state_q == StFree) & start_i & ~annul_i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFree;
            cnt_q      <= 6'd0;
            pr_q       <= 65'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ready_o    <= 1'b0;
            result_o   <= 64'd0;
        end else begin
            case (state_q)
                StFree: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        pr_q       <= {33'd0, op1_mag};
                        divisor_q  <= op2_mag;
                        cnt_q      <= 6'd0;
                        neg_quot_q <= op1_neg ^ op2_neg;
                        neg_rem_q  <= op1_neg;
`ifdef DIV_ZERO_FASTPATH_EN
                        state_q    <= (opdata2_i == 32'd0) ? StByZero : StOn;
`else
                        state_q    <= StOn;
`endif
                    end
                end
                StOn: begin
                    if (annul_i) begin
                        state_q <= StFree;
                    end else begin
                        pr_q  <= pr_step;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            state_q <= StEnd;
                        end
                    end
                end
`ifdef DIV_ZERO_FASTPATH_EN
                StByZero: begin
                    if (annul_i) begin
                        state_q <= StFree;
                    end else begin
                        // Zeroed remainder/quotient makes the fix-up yield 0.
                        pr_q    <= 65'd0;
                        state_q <= StEnd;
                    end
                end
`endif
                StEnd: begin
                    if (!start_i) begin
                        state_q  <= StFree;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end else begin
                        ready_o  <= 1'b1;
                        result_o <= {rem_fix, quot_fix};
                    end
                end
                default: begin
                    state_q  <= StFree;
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule
